// File: rtl/trace_req_queue.sv
// Trace request queue: buffers loader entries, drops invalid ops, and issues
// R/W requests to the cache in FIFO order with issued/dropped statistics.
module trace_req_queue #(
  parameter int ADDR_W = 48,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [7:0]               in_op,
  input  logic                     in_last,
  output logic                     in_ready,
  input  logic                     start,
  output logic                     req_valid,
  output logic [ADDR_W-1:0]        req_addr,
  output logic [7:0]               req_op,
  input  logic                     req_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         issued_cnt,
  output logic [CNT_W-1:0]         dropped_cnt,
  output logic                     busy,
  output logic                     done
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [PTR_W:0]     r_count;
  logic               r_last_seen;
  logic [CNT_W-1:0]   r_issued;
  logic [CNT_W-1:0]   r_dropped;
  logic [ADDR_W-1:0]  r_addr_mem [DEPTH];
  logic [7:0]         r_op_mem   [DEPTH];

  logic w_accept;
  logic w_op_ok;
  logic w_push;
  logic w_drop;
  logic w_pop;
  logic w_restart;

  // Occupancy can only reach DEPTH, so the count MSB alone flags full.
  always_comb begin
    in_ready  = !r_count[PTR_W] && !r_last_seen && (r_state != S_DONE);
    req_valid = (r_state == S_RUN) && (r_count != '0);
    w_accept  = in_valid && in_ready;
    w_op_ok   = (in_op == 8'h52) || (in_op == 8'h57);
    w_push    = w_accept && w_op_ok;
    w_drop    = w_accept && !w_op_ok;
    w_pop     = req_valid && req_ready;
    w_restart = (r_state == S_DONE) && start;
  end

  assign req_addr    = r_addr_mem[r_head];
  assign req_op      = r_op_mem[r_head];
  assign count       = r_count;
  assign issued_cnt  = r_issued;
  assign dropped_cnt = r_dropped;
  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_last_seen <= 1'b0;
      r_issued    <= '0;
      r_dropped   <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (start) r_state <= S_RUN;
        S_RUN:   if (r_last_seen && (r_count == '0)) r_state <= S_DONE;
        S_DONE:  if (start) r_state <= S_RUN;
        default: r_state <= S_IDLE;
      endcase

      if (w_push) r_tail <= PTR_W'(r_tail + 1);
      if (w_pop)  r_head <= PTR_W'(r_head + 1);

      case ({w_push, w_pop})
        2'b10:   r_count <= (PTR_W+1)'(r_count + 1);
        2'b01:   r_count <= (PTR_W+1)'(r_count - 1);
        default: ;
      endcase

      // No accept or issue is possible in DONE, so a restart cannot collide
      // with a counter update.
      if (w_restart) begin
        r_issued    <= '0;
        r_dropped   <= '0;
        r_last_seen <= 1'b0;
      end else begin
        if (w_accept && in_last)        r_last_seen <= 1'b1;
        if (w_pop && (r_issued != '1))  r_issued    <= CNT_W'(r_issued + 1);
        if (w_drop && (r_dropped != '1)) r_dropped  <= CNT_W'(r_dropped + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_mem[r_tail] <= in_addr;
      r_op_mem[r_tail]   <= in_op;
    end
  end

endmodule

// File: tb/tb_trace_req_queue.sv
// Bench for trace_req_queue: scoreboard of accepted valid entries checked
// against every request handshake, plus directed state/counter checks.
module tb_trace_req_queue;

  localparam int ADDR_W = 48;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [ADDR_W-1:0] in_addr;
  logic [7:0]        in_op;
  logic              in_last;
  logic              in_ready;
  logic              start;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_op;
  logic              req_ready;
  logic [4:0]        count;
  logic [CNT_W-1:0]  issued_cnt;
  logic [CNT_W-1:0]  dropped_cnt;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_errors = 0;
  int hs_cnt   = 0;
  logic [55:0] sb[$];
  logic [55:0] sb_exp;

  always #5 clk = ~clk;

  trace_req_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_addr(in_addr), .in_op(in_op), .in_last(in_last),
    .in_ready(in_ready), .start(start),
    .req_valid(req_valid), .req_addr(req_addr), .req_op(req_op), .req_ready(req_ready),
    .count(count), .issued_cnt(issued_cnt), .dropped_cnt(dropped_cnt),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: valid accepted entries queued, compared at each handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (req_valid && req_ready) begin
        hs_cnt++;
        if (sb.size() == 0) check("sb_underflow", 64'd1, 64'd0);
        else begin
          sb_exp = sb.pop_front();
          check("req_addr", 64'(req_addr), 64'(sb_exp[55:8]));
          check("req_op", 64'(req_op), 64'(sb_exp[7:0]));
        end
      end
      if (in_valid && in_ready && (in_op == 8'h52 || in_op == 8'h57))
        sb.push_back({in_addr, in_op});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [47:0] a, input logic [7:0] op, input logic last);
    in_valid = 1'b1;
    in_addr  = a;
    in_op    = op;
    in_last  = last;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
    end
    check("push_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check("done_wait", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_op = '0; in_last = 1'b0;
    start = 1'b0; req_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;

    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_issued", 64'(issued_cnt), 64'd0);
    check("rst_dropped", 64'(dropped_cnt), 64'd0);

    // Preload in IDLE, then ordered issue on consecutive cycles.
    req_ready = 1'b1;
    push(48'h7fff493822b8, 8'h57, 1'b0);
    push(48'h0000006324d8, 8'h52, 1'b0);
    push(48'h7fff493822b0, 8'h57, 1'b0);
    push(48'h7fff493822a8, 8'h57, 1'b1);
    check("pre_count", 64'(count), 64'd4);
    check("pre_req_valid", 64'(req_valid), 64'd0);
    check("pre_busy", 64'(busy), 64'd0);
    start_pulse();
    check("st_busy", 64'(busy), 64'd1);
    check("st_req_valid", 64'(req_valid), 64'd1);
    hs0 = hs_cnt;
    repeat (4) tick();
    check("pre_hs_consec", 64'(hs_cnt - hs0), 64'd4);
    check("pre_issued", 64'(issued_cnt), 64'd4);
    check("pre_count0", 64'(count), 64'd0);
    check("pre_done_early", 64'(done), 64'd0);
    tick();
    check("pre_done", 64'(done), 64'd1);
    check("pre_busy0", 64'(busy), 64'd0);
    check("pre_in_ready_done", 64'(in_ready), 64'd0);
    check("pre_dropped", 64'(dropped_cnt), 64'd0);
    check("pre_sb_empty", 64'(sb.size()), 64'd0);

    // Restart from DONE, then invalid-op drops.
    start_pulse();
    check("rs_issued", 64'(issued_cnt), 64'd0);
    check("rs_dropped", 64'(dropped_cnt), 64'd0);
    check("rs_busy", 64'(busy), 64'd1);
    check("rs_in_ready", 64'(in_ready), 64'd1);
    req_ready = 1'b0;
    push(48'h0000_1000_0000, 8'h52, 1'b0);
    push(48'h0000_1000_0008, 8'h41, 1'b0);
    push(48'h0000_1000_0010, 8'h57, 1'b0);
    push(48'h0000_1000_0018, 8'h00, 1'b1);
    check("drop_count", 64'(count), 64'd2);
    check("drop_dropped", 64'(dropped_cnt), 64'd2);
    check("drop_in_ready_last", 64'(in_ready), 64'd0);
    req_ready = 1'b1;
    wait_done();
    check("drop_issued", 64'(issued_cnt), 64'd2);
    check("drop_sb_empty", 64'(sb.size()), 64'd0);

    // Full queue under backpressure, then drain across pointer wrap.
    do_reset();
    start_pulse();
    req_ready = 1'b0;
    for (int i = 0; i < 16; i++)
      push(48'h7fff_0000_0000 + 48'(i * 16), (i % 2) ? 8'h57 : 8'h52, 1'b0);
    check("full_count", 64'(count), 64'd16);
    check("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_addr = 48'h7fff_0000_0100; in_op = 8'h52; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_hold_ready", 64'(in_ready), 64'd0);
      check("full_req_valid", 64'(req_valid), 64'd1);
      check("full_addr_stable", 64'(req_addr), 64'h7fff_0000_0000);
      check("full_count_hold", 64'(count), 64'd16);
    end
    @(posedge clk);
    #1;
    req_ready = 1'b1;
    @(negedge clk);
    check("full_nobypass", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    push(48'h7fff_0000_0100, 8'h52, 1'b1);
    wait_done();
    check("full_issued", 64'(issued_cnt), 64'd17);
    check("full_sb_empty", 64'(sb.size()), 64'd0);

    // Steady-state simultaneous push and pop.
    do_reset();
    start_pulse();
    req_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(48'h0000_2000_0000 + 48'(i), 8'h57, 1'b0);
    check("ss_count_init", 64'(count), 64'd3);
    req_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push(48'h0000_3000_0000 + 48'(i * 4), (i % 3 == 0) ? 8'h57 : 8'h52, 1'b0);
      check("ss_count", 64'(count), 64'd3);
    end
    check("ss_issued", 64'(issued_cnt), 64'd20);
    repeat (3) tick();
    check("ss_count_drained", 64'(count), 64'd0);
    check("ss_sb_empty", 64'(sb.size()), 64'd0);

    // Dropped last entry and restart.
    do_reset();
    start_pulse();
    req_ready = 1'b1;
    push(48'h0000_4000_0000, 8'h52, 1'b0);
    push(48'h0000_4000_0040, 8'h57, 1'b0);
    push(48'h0000_4000_0080, 8'h58, 1'b1);
    wait_done();
    check("dl_in_ready", 64'(in_ready), 64'd0);
    check("dl_dropped", 64'(dropped_cnt), 64'd1);
    check("dl_issued", 64'(issued_cnt), 64'd2);
    check("dl_busy", 64'(busy), 64'd0);
    start_pulse();
    check("dl_rs_issued", 64'(issued_cnt), 64'd0);
    check("dl_rs_dropped", 64'(dropped_cnt), 64'd0);
    check("dl_rs_busy", 64'(busy), 64'd1);
    check("dl_rs_done", 64'(done), 64'd0);
    check("dl_rs_in_ready", 64'(in_ready), 64'd1);
    push(48'h0000_4000_00c0, 8'h58, 1'b1);
    check("dl_empty_done_early", 64'(done), 64'd0);
    check("dl_empty_dropped", 64'(dropped_cnt), 64'd1);
    tick();
    check("dl_empty_done", 64'(done), 64'd1);

    // Mid-run reset.
    do_reset();
    start_pulse();
    req_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(48'h0000_5000_0000 + 48'(i), 8'h52, 1'b0);
    check("mr_count5", 64'(count), 64'd5);
    check("mr_busy", 64'(busy), 64'd1);
    do_reset();
    check("mr_count", 64'(count), 64'd0);
    check("mr_req_valid", 64'(req_valid), 64'd0);
    check("mr_busy0", 64'(busy), 64'd0);
    check("mr_done0", 64'(done), 64'd0);
    check("mr_issued", 64'(issued_cnt), 64'd0);
    check("mr_dropped", 64'(dropped_cnt), 64'd0);
    check("mr_in_ready", 64'(in_ready), 64'd1);

    // Counter saturation.
    start_pulse();
    req_ready = 1'b0;
    for (int i = 0; i < 4100; i++) push(48'(i), 8'h41, 1'b0);
    check("sat_dropped", 64'(dropped_cnt), 64'd4095);
    req_ready = 1'b1;
    for (int i = 0; i < 4100; i++) push(48'(i * 16), 8'h52, 1'b0);
    tick();
    check("sat_issued", 64'(issued_cnt), 64'd4095);
    check("sat_count", 64'(count), 64'd0);
    check("sat_sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/trace_req_queue.md
# trace_req_queue

Request queue and sequencer that sits directly upstream of `cache_top`. It buffers trace entries (48-bit address plus ASCII op byte) from a loader and validates each op: `8'h52` is read ('R'), `8'h57` is write ('W'), anything else is dropped. Valid entries are issued one per handshake to the cache request port, and the block reports issued/dropped counts plus a done flag once the marked last entry has drained.

## Interface
Parameters:
- `ADDR_W`, 48: address width.
- `DEPTH`, 16: queue entries; power of two, minimum 2.
- `CNT_W`, 12: width of statistics counters, matching the cache counter width.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `in_valid`, input, 1: loader entry valid.
- `in_addr`, input, `ADDR_W`: loader address.
- `in_op`, input, 8: loader op byte (ASCII).
- `in_last`, input, 1: the entry is the final one of the trace.
- `in_ready`, output, 1: queue accepts the entry this cycle.
- `start`, input, 1: single-cycle pulse that begins or restarts issue.
- `req_valid`, output, 1: cache request valid.
- `req_addr`, output, `ADDR_W`: request address; this is the queue head.
- `req_op`, output, 8: request op; always `8'h52` or `8'h57`.
- `req_ready`, input, 1: cache accepts the request.
- `count`, output, log2(DEPTH)+1: current occupancy.
- `issued_cnt`, output, `CNT_W`: number of requests handshaken.
- `dropped_cnt`, output, `CNT_W`: number of entries discarded for an invalid op.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: high while in DONE.

## Operation
- **States:**
  - IDLE (reset state).
  - RUN.
  - DONE.
- **Transitions:**
  - IDLE -> RUN on `start`.
  - RUN -> DONE when `last_seen` and `count == 0`. Both are registered values, sampled at the edge.
  - DONE -> RUN on `start`. This clears `issued_cnt`, `dropped_cnt` and `last_seen`.
  - `start` in RUN is ignored.
- **Accept:**
  - `in_ready = (count < DEPTH) && !last_seen && state != DONE`.
  - Pushes are allowed in IDLE, which preloads the queue.
  - A transfer occurs when `in_valid && in_ready`.
- **Op validation:**
  - An accepted entry with `in_op` of `8'h52` or `8'h57` is written to the tail.
  - An accepted entry with any other op is not stored, and `dropped_cnt` increments.
- **Last marker:** any accepted entry with `in_last` sets `last_seen`, whether it is stored or dropped.
- **Issue:**
  - `req_valid = (state == RUN) && (count != 0)`.
  - A handshake occurs when `req_valid && req_ready`. It pops the head and increments `issued_cnt`.
- **Request stability:** `req_addr` and `req_op` must hold stable while `req_valid && !req_ready`.
- **Storage:** circular buffer with head/tail pointers that wrap modulo DEPTH. `count` tracks occupancy.
- **Simultaneous push of a valid entry and pop:** `count` is unchanged and both pointers advance.
- **Push of a dropped entry together with a pop:** `count` decrements.
- **Full:** `in_ready = 0` and there is no bypass. This holds even if a pop occurs in the same cycle.
- **Empty:** `req_valid = 0`. There is no same-cycle bypass from input to request.
- **Counters:** saturate at 2^CNT_W-1 and never wrap.
- **Reset:** takes priority over everything, including mid-RUN.
  - state = IDLE.
  - Pointers, `count`, counters and `last_seen` = 0.
  - Queue contents become don't-care.

## Timing
- **Reset values:**
  - `in_ready` = 1.
  - `req_valid`, `busy`, `done` = 0.
  - `count`, `issued_cnt`, `dropped_cnt` = 0.
  - `req_addr` and `req_op` are don't-care while `req_valid = 0`.
- **Accept-to-issue latency:** an entry accepted at edge N appears on `req_*` in cycle N+1 when the queue was empty and the block is in RUN. Minimum latency is 1 cycle.
- **Throughput:** one accept and one issue per cycle, sustained.
- **Start-to-issue:** a `start` pulse at edge N gives `busy = 1` and `req_valid` (if the queue is non-empty) in cycle N+1.
- **Done latency:**
  - The final handshake at edge N gives `count = 0` after N.
  - `done = 1` and `busy = 0` from cycle N+2 onward.
  - A last entry that is dropped into an empty queue in RUN gives `done` two cycles after acceptance.
- **Counter timing:** `issued_cnt` and `dropped_cnt` update at the same edge as the handshake they count.

## Test plan
- **Preload and ordered issue:**
  - Stimulus: push 4 entries in IDLE (addr `0x7fff493822b8` W, `0x0000006324d8` R, `0x7fff493822b0` W, `0x7fff493822a8` W with last), then `start` with `req_ready = 1`.
  - Required: 4 requests in order on consecutive cycles, `issued_cnt = 4`, `dropped_cnt = 0`, `done = 1` two cycles after the 4th handshake.
- **Invalid op drop:**
  - Stimulus: push ops `0x52`, `0x41`, `0x57`, `0x00`.
  - Required: only 2 requests issued, `dropped_cnt = 2`, `count` peaks at 2.
- **Full and backpressure:**
  - Stimulus: `req_ready = 0` in RUN, push 17 valid entries.
  - Required: `in_ready = 0` after 16 (`count = 16`), 17th held by the loader, `req_addr` stable throughout. Then `req_ready = 1` drains 16 with pointer wrap and correct order.
- **Simultaneous push/pop at steady state:**
  - Stimulus: `count = 3`, `in_valid = 1` and `req_ready = 1` for 20 cycles.
  - Required: `count` stays 3, `issued_cnt = 20`, FIFO order preserved.
- **Dropped last and restart:**
  - Stimulus: last entry has op `0x58`.
  - Required: `done` asserts once the queue empties, `in_ready = 0` in DONE. A `start` pulse clears both counters to 0 and returns the block to RUN with `in_ready = 1`.
- **Mid-run reset:**
  - Stimulus: assert `reset` for one cycle with `count = 5` in RUN.
  - Required: next cycle `count = 0`, `req_valid = 0`, state IDLE, counters 0, `in_ready = 1`.
